// File: rtl/exercise1_pkg.sv
// Shared types and default widths for the exercise1 min/max memory scanner.
package exercise1_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/exercise1.sv
// Sequential min/max scanner: walks every address of a combinationally read
// memory once per start request and reports the unsigned maximum and minimum.
module exercise1
    import exercise1_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] DATA,
    output logic [DATA_WIDTH-1:0] MAX,
    output logic [DATA_WIDTH-1:0] MIN,
    output logic                  done
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_max;
    logic [DATA_WIDTH-1:0] r_min;
    logic                  r_done;
    logic                  w_last;

    // The address register doubles as the scan counter; all ones marks the final location.
    assign w_last = &r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_max   <= '0;
            r_min   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= SCAN;
                        r_addr  <= '0;
                        r_max   <= '0;
                        r_min   <= '1;
                    end
                end
                SCAN: begin
                    if (DATA > r_max) r_max <= DATA;
                    if (DATA < r_min) r_min <= DATA;
                    r_addr <= r_addr + 1'b1;
                    if (w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    // Results hold until start is released; a held start never retriggers.
                    if (!start) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ADDR = r_addr;
    assign MAX  = r_max;
    assign MIN  = r_min;
    assign done = r_done;

endmodule

// File: tb/tb_exercise1.sv
// Self-checking bench for exercise1: memory model, randomized fills and a
// reference max/min computed directly over the memory contents.
module tb_exercise1;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] w_max;
    logic [DW-1:0] w_min;
    logic          w_done;

    logic [DW-1:0] mem [0:DEPTH-1];

    int n_vec;
    int n_err;

    assign w_data = mem[w_addr];

    exercise1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ADDR  (w_addr),
        .DATA  (w_data),
        .MAX   (w_max),
        .MIN   (w_min),
        .done  (w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_max();
        int m = 0;
        for (int i = 0; i < DEPTH; i++) if (int'(mem[i]) > m) m = int'(mem[i]);
        return m[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] ref_min();
        int m = (1 << DW) - 1;
        for (int i = 0; i < DEPTH; i++) if (int'(mem[i]) < m) m = int'(mem[i]);
        return m[DW-1:0];
    endfunction

    task automatic fill_const(input logic [DW-1:0] v);
        for (int i = 0; i < DEPTH; i++) mem[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, (1 << DW) - 1));
    endtask

    // Expects start already high and the next rising edge to be E0 (sampled in IDLE).
    task automatic wait_done(input string tag);
        int n;
        @(posedge clk);
        #1;
        check({tag, ".addr0"}, 32'(w_addr), 32'd0);
        check({tag, ".busy"}, 32'(w_done), 32'd0);
        n = 0;
        while (n < 2 * DEPTH) begin
            @(posedge clk);
            #1;
            n++;
            if (w_done) break;
        end
        check({tag, ".latency"}, n, DEPTH);
        check({tag, ".max"}, 32'(w_max), 32'(ref_max()));
        check({tag, ".min"}, 32'(w_min), 32'(ref_min()));
        check({tag, ".addr_done"}, 32'(w_addr), 32'd0);
    endtask

    // Releases start (returning to IDLE) and then launches a fresh scan.
    task automatic do_scan(input string tag);
        logic [DW-1:0] kmax, kmin;
        kmax = w_max;
        kmin = w_min;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".done_drop"}, 32'(w_done), 32'd0);
        check({tag, ".max_keep"}, 32'(w_max), 32'(kmax));
        check({tag, ".min_keep"}, 32'(w_min), 32'(kmin));
        @(negedge clk);
        start = 1'b1;
        wait_done(tag);
    endtask

    initial begin
        logic [DW-1:0] fmax, fmin;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        fill_rand();
        #1;
        check("rst.addr", 32'(w_addr), 32'd0);
        check("rst.max", 32'(w_max), 32'd0);
        check("rst.min", 32'(w_min), 32'd0);
        check("rst.done", 32'(w_done), 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        rst_n = 1'b1;
        wait_done("rand1");

        fmax = w_max;
        fmin = w_min;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("hold.done", 32'(w_done), 32'd1);
            check("hold.max", 32'(w_max), 32'(fmax));
            check("hold.min", 32'(w_min), 32'(fmin));
        end

        fill_const(8'h5A);
        do_scan("all5a");
        check("all5a.eq", 32'(w_max), 32'h5A);

        fill_const(8'h80);
        mem[0] = 8'h00;
        mem[DEPTH-1] = 8'hFF;
        do_scan("bound");
        check("bound.min", 32'(w_min), 32'h00);
        check("bound.max", 32'(w_max), 32'hFF);

        fill_const(8'hFF);
        do_scan("allff");
        fill_const(8'h00);
        do_scan("all00");

        for (int r = 0; r < 3; r++) begin
            fill_rand();
            mem[$urandom_range(0, DEPTH - 1)] = DW'($urandom_range(0, (1 << DW) - 1));
            do_scan("randN");
        end

        // Reset mid-scan with start held high
        fill_rand();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (500) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.addr", 32'(w_addr), 32'd0);
        check("midrst.max", 32'(w_max), 32'd0);
        check("midrst.min", 32'(w_min), 32'd0);
        check("midrst.done", 32'(w_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done("postrst");

        fill_rand();
        do_scan("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
